// File: rtl/overture_pkg.sv
// Shared types for the Overture register file: instruction classes, field
// codes, FSM states and the illegal-instruction decode.
package overture_pkg;

  localparam int OVT_DATA_W = 8;

  typedef enum logic [1:0] {
    CLS_IMM  = 2'b00,
    CLS_CALC = 2'b01,
    CLS_COPY = 2'b10,
    CLS_COND = 2'b11
  } instr_class_e;

  // COPY field code that selects the input/output port instead of a register
  localparam logic [2:0] PORT_CODE    = 3'd6;
  localparam logic [2:0] ILLEGAL_CODE = 3'd7;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  // CALC may only name ops 0-5; COPY may not use code 7 in either field
  function automatic logic is_illegal(input logic [7:0] instr);
    logic bad;
    bad = 1'b0;
    case (instr_class_e'(instr[7:6]))
      CLS_CALC: bad = (instr[2:0] == PORT_CODE) || (instr[2:0] == ILLEGAL_CODE);
      CLS_COPY: bad = (instr[5:3] == ILLEGAL_CODE) || (instr[2:0] == ILLEGAL_CODE);
      default:  bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/overture_regfile_if.sv
// Instruction, ALU and I/O port bundle of the Overture register file.
// slave = the register file, master = whoever drives instructions and ports.
interface overture_regfile_if
  import overture_pkg::*;
#(
  parameter int DATA_W = OVT_DATA_W
);
  logic              instr_valid;
  logic [7:0]        instr;
  logic              instr_ready;
  logic [DATA_W-1:0] alu_in1;
  logic [DATA_W-1:0] alu_in2;
  logic [7:0]        alu_op;
  logic [DATA_W-1:0] alu_result;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic [DATA_W-1:0] jump_target;
  logic [DATA_W-1:0] cond_value;

  modport slave (
    input  instr_valid, instr, alu_result, in_valid, in_data, out_ready,
    output instr_ready, alu_in1, alu_in2, alu_op, in_ready,
           out_valid, out_data, jump_target, cond_value
  );

  modport master (
    output instr_valid, instr, alu_result, in_valid, in_data, out_ready,
    input  instr_ready, alu_in1, alu_in2, alu_op, in_ready,
           out_valid, out_data, jump_target, cond_value
  );
endinterface

// File: rtl/overture_out_buf.sv
// One-entry output port buffer. The caller only asserts load_i when the
// slot is free or draining in the same cycle.
module overture_out_buf
  import overture_pkg::*;
#(
  parameter int DATA_W = OVT_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [DATA_W-1:0] load_data_i,
  input  logic              drain_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;

  // Load wins over drain so a simultaneous drain+load keeps the slot full
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= load_data_i;
    end else if (valid_q && drain_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/overture_regfile.sv
// Overture register file r0-r5 with instruction decode, ALU operand/result
// routing and COPY access to the input/output ports.
// Optional feature: OVERTURE_REGFILE_ILLEGAL_HALT_EN turns an illegal
// instruction into a permanent HALT and adds the halted port.
module overture_regfile
  import overture_pkg::*;
#(
  parameter int DATA_W = OVT_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  overture_regfile_if.slave bus
`ifdef OVERTURE_REGFILE_ILLEGAL_HALT_EN
  ,
  output logic              halted
`endif
);

  instr_class_e      cls;
  logic [2:0]        src;
  logic [2:0]        dst;
  logic              illegal;
  logic              need_in;
  logic              need_out;
  logic              stall;
  logic              ready;
  logic              accept;
  logic [DATA_W-1:0] src_val;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [DATA_W-1:0] regs_q [6];
  logic [DATA_W-1:0] regs_d [6];
  state_e            state_q;

  // Decode the presented instruction and work out whether it can go this cycle
  always_comb begin
    cls      = instr_class_e'(bus.instr[7:6]);
    src      = bus.instr[5:3];
    dst      = bus.instr[2:0];
    illegal  = is_illegal(bus.instr);
    need_in  = (cls == CLS_COPY) && !illegal && (src == PORT_CODE);
    need_out = (cls == CLS_COPY) && !illegal && (dst == PORT_CODE);
    stall    = (need_in && !bus.in_valid) || (need_out && out_valid && !bus.out_ready);
    // rst_n gating keeps the handshake dead while reset is held
    ready    = rst_n && (state_q == ST_RUN) && !stall;
    accept   = bus.instr_valid && ready;
    src_val  = '0;
    if (src < PORT_CODE) begin
      src_val = regs_q[src];
    end else if (src == PORT_CODE) begin
      src_val = bus.in_data;
    end
  end

  // Next register contents for the accepted instruction
  always_comb begin
    regs_d = regs_q;
    if (accept && !illegal) begin
      case (cls)
        CLS_IMM:  regs_d[0] = DATA_W'(bus.instr[5:0]);
        CLS_CALC: regs_d[3] = bus.alu_result;
        CLS_COPY: if (dst < PORT_CODE) regs_d[dst] = src_val;
        default:  ;
      endcase
    end
  end

  // Architectural registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 6; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // RUN/HALT control; only reset leaves HALT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
`ifdef OVERTURE_REGFILE_ILLEGAL_HALT_EN
    end else if (accept && illegal) begin
      state_q <= ST_HALT;
`endif
    end else begin
      state_q <= state_q;
    end
  end

  overture_out_buf #(
    .DATA_W (DATA_W)
  ) u_out_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (accept && need_out),
    .load_data_i (src_val),
    .drain_i     (bus.out_ready),
    .valid_o     (out_valid),
    .data_o      (out_data)
  );

  assign bus.instr_ready = ready;
  assign bus.in_ready    = accept && need_in;
  assign bus.alu_in1     = regs_q[1];
  assign bus.alu_in2     = regs_q[2];
  assign bus.alu_op      = bus.instr;
  assign bus.out_valid   = out_valid;
  assign bus.out_data    = out_data;
  assign bus.jump_target = regs_q[0];
  assign bus.cond_value  = regs_q[3];

`ifdef OVERTURE_REGFILE_ILLEGAL_HALT_EN
  assign halted = (state_q == ST_HALT);
`endif

endmodule

// File: tb/tb_overture_regfile.sv
// Scoreboard bench for overture_regfile: each issued instruction pushes the
// hand-computed architectural state expected after it is accepted; a monitor
// compares that state one cycle after every observed accept.
module tb_overture_regfile;

  typedef struct packed {
    logic [7:0] jt;
    logic [7:0] a1;
    logic [7:0] a2;
    logic [7:0] cv;
    logic       ov;
    logic [7:0] od;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  overture_regfile_if bus ();

`ifdef OVERTURE_REGFILE_ILLEGAL_HALT_EN
  logic halted;
`endif

  overture_regfile dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef OVERTURE_REGFILE_ILLEGAL_HALT_EN
    ,
    .halted(halted)
`endif
  );

  // ArithmeticEngine stand-in: op 100 adds, op 101 subtracts
  assign bus.alu_result = (bus.alu_op[2:0] == 3'b100) ? bus.alu_in1 + bus.alu_in2 :
                          (bus.alu_op[2:0] == 3'b101) ? bus.alu_in1 - bus.alu_in2 : 8'h00;

  exp_t exp_q[$];
  int   vectors    = 0;
  int   miscompares = 0;
  logic pend = 1'b0;

  function automatic exp_t mk(input logic [7:0] jt, input logic [7:0] a1,
                              input logic [7:0] a2, input logic [7:0] cv,
                              input logic ov, input logic [7:0] od);
    exp_t e;
    e = {jt, a1, a2, cv, ov, od};
    return e;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: compare state one cycle after each accept
  always @(negedge clk) begin
    exp_t got;
    exp_t e;
    if (pend) begin
      got = {bus.jump_target, bus.alu_in1, bus.alu_in2, bus.cond_value,
             bus.out_valid, bus.out_data};
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL sb_unexpected_accept: got state %h, expected no accept at %0t", got, $time);
      end else begin
        e = exp_q.pop_front();
        if (got !== e)
          begin
            miscompares++;
            $display("FAIL sb_state: got jt=%h a1=%h a2=%h cv=%h ov=%b od=%h, expected jt=%h a1=%h a2=%h cv=%h ov=%b od=%h",
                     got.jt, got.a1, got.a2, got.cv, got.ov, got.od,
                     e.jt, e.a1, e.a2, e.cv, e.ov, e.od);
          end
      end
    end
    pend <= rst_n && bus.instr_valid && bus.instr_ready;
  end

  // Present one instruction until accepted (bounded)
  task automatic issue(input logic [7:0] ins, input exp_t e);
    bit done;
    done = 1'b0;
    exp_q.push_back(e);
    bus.instr       = ins;
    bus.instr_valid = 1'b1;
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge clk);
      if (bus.instr_ready === 1'b1) done = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.instr_valid = 1'b0;
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL issue_timeout: instr %h never accepted, expected accept within 20 cycles", ins);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.instr_valid = 1'b0;
    bus.instr       = 8'h00;
    bus.in_valid    = 1'b0;
    bus.in_data     = 8'h00;
    bus.out_ready   = 1'b0;
    rst_n           = 1'b0;

    // Reset state with every request active
    bus.instr       = 8'hB6;
    bus.instr_valid = 1'b1;
    bus.in_valid    = 1'b1;
    bus.out_ready   = 1'b1;
    @(negedge clk);
    check("rst_instr_ready", 8'(bus.instr_ready), 8'h00);
    check("rst_in_ready",    8'(bus.in_ready),    8'h00);
    check("rst_jump_target", bus.jump_target,     8'h00);
    check("rst_alu_in1",     bus.alu_in1,         8'h00);
    check("rst_alu_in2",     bus.alu_in2,         8'h00);
    check("rst_cond_value",  bus.cond_value,      8'h00);
    check("rst_out_valid",   8'(bus.out_valid),   8'h00);
    check("rst_out_data",    bus.out_data,        8'h00);
    check("alu_op_pass",     bus.alu_op,          8'hB6);
`ifdef OVERTURE_REGFILE_ILLEGAL_HALT_EN
    check("rst_halted",      8'(halted),          8'h00);
`endif
    bus.instr_valid = 1'b0;
    bus.in_valid    = 1'b0;
    bus.out_ready   = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // IMM and register COPY
    issue(8'h2A, mk(8'h2A, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00));
    issue(8'h81, mk(8'h2A, 8'h2A, 8'h00, 8'h00, 1'b0, 8'h00));
    issue(8'h05, mk(8'h05, 8'h2A, 8'h00, 8'h00, 1'b0, 8'h00));
    issue(8'h81, mk(8'h05, 8'h05, 8'h00, 8'h00, 1'b0, 8'h00));
    issue(8'h03, mk(8'h03, 8'h05, 8'h00, 8'h00, 1'b0, 8'h00));
    issue(8'h82, mk(8'h03, 8'h05, 8'h03, 8'h00, 1'b0, 8'h00));

    // CALC write-back into r3: 5+3 then 5-3
    issue(8'h44, mk(8'h03, 8'h05, 8'h03, 8'h08, 1'b0, 8'h00));
    issue(8'h45, mk(8'h03, 8'h05, 8'h03, 8'h02, 1'b0, 8'h00));

    // COPY 6->2 stalled on the input port for three cycles
    exp_q.push_back(mk(8'h03, 8'h05, 8'h77, 8'h02, 1'b0, 8'h00));
    bus.instr       = 8'hB2;
    bus.instr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("in_stall_instr_ready", 8'(bus.instr_ready), 8'h00);
      check("in_stall_in_ready",    8'(bus.in_ready),    8'h00);
      @(posedge clk);
      #1;
    end
    bus.in_data  = 8'h77;
    bus.in_valid = 1'b1;
    @(negedge clk);
    check("in_go_instr_ready", 8'(bus.instr_ready), 8'h01);
    check("in_go_in_ready",    8'(bus.in_ready),    8'h01);
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
    @(negedge clk);
    check("in_ready_one_cycle", 8'(bus.in_ready), 8'h00);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;

    issue(8'h93, mk(8'h03, 8'h05, 8'h77, 8'h77, 1'b0, 8'h00));

    // Output port: first load, second stalls, then drain+load together
    bus.out_ready = 1'b0;
    issue(8'h8E, mk(8'h03, 8'h05, 8'h77, 8'h77, 1'b1, 8'h05));
    exp_q.push_back(mk(8'h03, 8'h05, 8'h77, 8'h77, 1'b1, 8'h77));
    bus.instr       = 8'h9E;
    bus.instr_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("out_stall_instr_ready", 8'(bus.instr_ready), 8'h00);
      check("out_stall_data",        bus.out_data,        8'h05);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("out_go_instr_ready", 8'(bus.instr_ready), 8'h01);
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;

    // Self COPY drains the buffer (out_ready still high), COND writes nothing
    issue(8'h9B, mk(8'h03, 8'h05, 8'h77, 8'h77, 1'b0, 8'h77));
    issue(8'hC5, mk(8'h03, 8'h05, 8'h77, 8'h77, 1'b0, 8'h77));

    // Pending output, then an illegal CALC op 111
    bus.out_ready = 1'b0;
    issue(8'h86, mk(8'h03, 8'h05, 8'h77, 8'h77, 1'b1, 8'h03));
    issue(8'h47, mk(8'h03, 8'h05, 8'h77, 8'h77, 1'b1, 8'h03));
`ifdef OVERTURE_REGFILE_ILLEGAL_HALT_EN
    bus.instr       = 8'h2A;
    bus.instr_valid = 1'b1;
    bus.out_ready   = 1'b1;
    @(negedge clk);
    check("halt_halted",      8'(halted),          8'h01);
    check("halt_instr_ready", 8'(bus.instr_ready), 8'h00);
    check("halt_out_pending", 8'(bus.out_valid),   8'h01);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("halt_out_drained",   8'(bus.out_valid),   8'h00);
    check("halt_instr_ready_2", 8'(bus.instr_ready), 8'h00);
    bus.instr_valid = 1'b0;
`else
    bus.out_ready = 1'b1;
    issue(8'hB9, mk(8'h03, 8'h05, 8'h77, 8'h77, 1'b0, 8'h03));
    issue(8'h46, mk(8'h03, 8'h05, 8'h77, 8'h77, 1'b0, 8'h03));
`endif

    // Plain reset clears HALT
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
`ifdef OVERTURE_REGFILE_ILLEGAL_HALT_EN
    check("reset_clears_halted", 8'(halted), 8'h00);
`endif
    check("reset_r3", bus.cond_value, 8'h00);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset while output is full and COPY 6->6 stalls
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    issue(8'h11, mk(8'h11, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00));
    issue(8'h86, mk(8'h11, 8'h00, 8'h00, 8'h00, 1'b1, 8'h11));
    bus.instr       = 8'hB6;
    bus.instr_valid = 1'b1;
    @(negedge clk);
    check("mid_stall_instr_ready", 8'(bus.instr_ready), 8'h00);
    check("mid_out_valid_before",  8'(bus.out_valid),   8'h01);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid",   8'(bus.out_valid),   8'h00);
    check("mid_rst_out_data",    bus.out_data,        8'h00);
    check("mid_rst_jump_target", bus.jump_target,     8'h00);
    check("mid_rst_instr_ready", 8'(bus.instr_ready), 8'h00);
    bus.instr_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // COPY 6->6 with both port conditions met
    bus.in_data   = 8'h5A;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    issue(8'hB6, mk(8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 8'h5A));
    bus.in_valid = 1'b0;

    repeat (2) @(negedge clk);
    check("sb_all_consumed", 8'(exp_q.size()), 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/overture_regfile.md
# overture_regfile

Architectural register file and I/O port stage of the 8-bit Overture datapath. Holds r0–r5, decodes one instruction byte per handshake, feeds r1/r2 and the op byte to ArithmeticEngine and writes its result back into r3. It also services COPY instructions to and from the external input and output ports with valid/ready handshakes, and exposes r0 and r3 to the downstream condition/jump stage.

## Interface
- DATA_W, 8, datapath width; the only supported value is 8.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- instr_valid  in  1  instruction byte present.
- instr  in  8  instruction byte.
- instr_ready  out  1  instruction is consumed this cycle when instr_valid is also high.
- alu_in1  out  8  r1, registered.
- alu_in2  out  8  r2, registered.
- alu_op  out  8  equals instr; combinational pass-through.
- alu_result  in  8  ArithmeticEngine output; combinational.
- in_valid  in  1  input port has data.
- in_data  in  8  input port data.
- in_ready  out  1  input port data is consumed this cycle.
- out_valid  out  1  output buffer is full.
- out_data  out  8  output buffer data.
- out_ready  in  1  output sink accepts the data.
- jump_target  out  8  r0.
- cond_value  out  8  r3.
- halted  out  1  illegal instruction seen; only present when the macro is defined.

## Operation
- Instruction class is instr[7:6].
  - 00 IMM: r0 <= {2'b00, instr[5:0]}.
  - 01 CALC: r3 <= alu_result. Illegal when instr[2:0] is 110 or 111.
  - 10 COPY: source is instr[5:3], destination is instr[2:0].
    - Codes 0–5 select r0–r5.
    - Source 6 is the input port; destination 6 is the output port.
    - Code 7 in either field is illegal.
  - 11 COND: no register write; consumed in one cycle. The downstream stage evaluates it.
- Source 6 (input port):
  - Requires in_valid; otherwise the instruction stalls.
  - in_ready = accept && (source is 6). It is never asserted outside an accepting cycle.
- Destination 6 (output port):
  - Requires (!out_valid || out_ready); otherwise the instruction stalls.
  - On accept: out_data <= source value and out_valid <= 1.
- The output buffer holds one entry.
  - When out_valid && out_ready, it empties unless it is reloaded in the same cycle.
  - A simultaneous drain and load keeps out_valid=1 with the new data.
- COPY 6→6 needs both port conditions in the same cycle.
- COPY to the same register (for example 3→3) is a legal no-op write.
- instr_ready = RUN && no stall condition. It is low during reset.
- FSM states: RUN and HALT.
  - RUN → HALT on accepting an illegal instruction, only when the macro is defined.
  - HALT is left only by reset.
  - In HALT, instr_ready=0 and in_ready=0. The output buffer still drains.

## Timing
- Reset values:
  - r0–r5 = 0.
  - out_valid=0, out_data=0.
  - halted=0, state=RUN.
  - instr_ready=0 and in_ready=0 while rst_n=0.
- Throughput is one instruction per cycle when there is no stall.
- A write accepted in cycle N is visible on alu_in1, alu_in2, jump_target and cond_value in cycle N+1.
- out_valid rises in cycle N+1 after the accepting cycle N.
- alu_result is sampled in the accepting cycle. Its path from alu_in1/alu_in2/alu_op is purely combinational.
- Reset asserted mid-operation discards the output buffer contents. No handshake completes in that cycle.

## Configuration
- Macro: OVERTURE_REGFILE_ILLEGAL_HALT_EN.
- Defined:
  - An illegal instruction is accepted, performs no write and moves the FSM to HALT.
  - The halted port exists; it is 1 in HALT and 0 otherwise.
- Undefined:
  - An illegal instruction is accepted as a NOP.
  - There is no HALT state and no halted port.

## Structure
- overture_pkg holds:
  - The instruction class enum (IMM, CALC, COPY, COND).
  - The port code constant (3'd6) and the illegal code constant (3'd7).
  - The state enum (RUN, HALT).
- One sub-module, overture_out_buf: the one-entry output buffer with load/drain handshake.

## Test plan
- After reset, IMM 0x2A then COPY 0→1 → jump_target=0x2A, then alu_in1=0x2A one cycle later. All outputs are 0 before the first accept.
- Set r1=5 and r2=3, then CALC with op 100 while ArithmeticEngine is connected → cond_value=0x08. With op 101 → cond_value=0x02.
- COPY 6→2 with in_valid=0 for 3 cycles, then in_data=0x77 with in_valid=1 → instr_ready=0 for 3 cycles; in_ready pulses for exactly one cycle; alu_in2=0x77 in the next cycle.
- Two back-to-back COPY 3→6 with out_ready=0 → the first is accepted and out_valid=1; the second stalls. Raising out_ready drains the first and loads the second in the same cycle; out_valid stays 1.
- With the macro defined, CALC op 111 → halted=1 and instr_ready stays 0. A pending output still drains. Reset clears halted. Without the macro, the same instruction leaves all registers unchanged.
- Assert rst_n=0 while out_valid=1 and a COPY 6→6 is stalled → out_valid=0 immediately and all registers read 0.
